// File: rtl/fir_ctrl.sv
// fir_ctrl: sequencing controller for a time-multiplexed NTAPS-tap FIR.
// One multiply-accumulate is reused across all taps of each accepted sample.
// Also holds the run-time coefficient bank, gates result-memory writes
// until the delay line is full, and generates the wrapping write address.
// Build option: define FIR_SAT_EN for a saturating accumulator; by default
// the accumulator wraps modulo 2^DW.
module fir_ctrl #(
    parameter int DW        = 8,
    parameter int NTAPS     = 3,
    parameter int MEM_DEPTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DW-1:0]                in_data,
    output logic                         in_ready,
    input  logic                         cfg_we,
    input  logic [$clog2(NTAPS)-1:0]     cfg_addr,
    input  logic [DW-1:0]                cfg_data,
    output logic                         cfg_err,
    output logic                         busy,
    output logic                         out_valid,
    output logic [DW-1:0]                out_data,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr
);

    // state | meaning
    // IDLE  | waiting for a sample; coefficient writes allowed
    // MAC   | one tap per cycle, k = 0 .. NTAPS-1
    // OUT   | acc presented on out_data for one cycle
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam int AW  = $clog2(NTAPS);
    localparam int MAW = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0]  K_LAST    = AW'(NTAPS - 1);
    localparam logic [AW-1:0]  FILL_MAX  = AW'(NTAPS - 1);
    localparam logic [MAW-1:0] ADDR_LAST = MAW'(MEM_DEPTH - 1);

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] tap_q  [NTAPS];
    logic [DW-1:0] tap_d  [NTAPS];
    logic [DW-1:0] coef_q [NTAPS];
    logic [DW-1:0] coef_d [NTAPS];
    logic [DW-1:0] acc_q, acc_d;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] fill_q, fill_d;
    // Set at acceptance when the delay line already held NTAPS-1 real samples.
    logic          wr_arm_q, wr_arm_d;
    logic [MAW-1:0] addr_q, addr_d;
    logic          cfg_err_q, cfg_err_d;

    logic [DW-1:0] cur_coef;
    logic [DW-1:0] cur_tap;
    logic [DW-1:0] mac_sum;
    logic          cfg_ok;

    // Select the coefficient/tap pair for the current MAC step.
    always_comb begin
        cur_coef = '0;
        cur_tap  = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (k_q == AW'(i)) begin
                cur_coef = coef_q[i];
                cur_tap  = tap_q[i];
            end
        end
    end

`ifdef FIR_SAT_EN
    logic [2*DW-1:0] prod_full;
    logic [2*DW:0]   sum_full;

    // Saturating accumulate: once clamped, further non-negative terms keep it clamped.
    always_comb begin
        prod_full = (2*DW)'(cur_coef) * (2*DW)'(cur_tap);
        sum_full  = (2*DW+1)'(acc_q) + (2*DW+1)'(prod_full);
        if (sum_full > (2*DW+1)'({DW{1'b1}})) begin
            mac_sum = {DW{1'b1}};
        end else begin
            mac_sum = sum_full[DW-1:0];
        end
    end
`else
    logic [DW-1:0] prod_w;

    // Wrapping accumulate: product and sum both truncated to DW bits.
    always_comb begin
        prod_w  = cur_coef * cur_tap;
        mac_sum = acc_q + prod_w;
    end
`endif

    // Next-state logic: FSM, delay line, coefficient bank, fill and address tracking.
    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        coef_d   = coef_q;
        acc_d    = acc_q;
        k_d      = k_q;
        fill_d   = fill_q;
        wr_arm_d = wr_arm_q;
        addr_d   = addr_q;

        cfg_ok    = cfg_we && (state_q == S_IDLE) && (int'(cfg_addr) < NTAPS);
        cfg_err_d = cfg_we && !cfg_ok;
        for (int i = 0; i < NTAPS; i++) begin
            if (cfg_ok && (cfg_addr == AW'(i))) begin
                coef_d[i] = cfg_data;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    tap_d[0] = in_data;
                    for (int i = 1; i < NTAPS; i++) begin
                        tap_d[i] = tap_q[i-1];
                    end
                    acc_d    = '0;
                    k_d      = '0;
                    wr_arm_d = (fill_q == FILL_MAX);
                    if (fill_q != FILL_MAX) begin
                        fill_d = fill_q + AW'(1);
                    end
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = mac_sum;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = S_OUT;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            S_OUT: begin
                if (wr_arm_q) begin
                    addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + MAW'(1);
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register update with synchronous reset; reset also aborts a sequence in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < NTAPS; i++) begin
                tap_q[i]  <= '0;
                coef_q[i] <= DW'(1);
            end
            acc_q     <= '0;
            k_q       <= '0;
            fill_q    <= '0;
            wr_arm_q  <= 1'b0;
            addr_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            coef_q    <= coef_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            fill_q    <= fill_d;
            wr_arm_q  <= wr_arm_d;
            addr_q    <= addr_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_MAC);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_valid ? acc_q : '0;
    assign mem_we    = out_valid && wr_arm_q;
    assign mem_addr  = addr_q;
    assign cfg_err   = cfg_err_q;

endmodule
